// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: request/status bundle between a frame source and uart_tx_frame.
// The master side drives the frame request; the slave side is the transmitter.
interface uart_tx_frame_if #(
  parameter int NUM_BYTES = 24
);
  localparam int LW = $clog2(NUM_BYTES + 1);

  logic                   i_Tx_DV;
  logic [NUM_BYTES*8-1:0] i_Tx_Data;
  logic [LW-1:0]          i_Tx_Len;
  logic                   o_Tx_Ready;
  logic                   o_Tx_Active;
  logic                   o_Tx_Serial;
  logic                   o_Tx_Byte_Done;
  logic                   o_Tx_Done;

  modport master (
    output i_Tx_DV,
    output i_Tx_Data,
    output i_Tx_Len,
    input  o_Tx_Ready,
    input  o_Tx_Active,
    input  o_Tx_Serial,
    input  o_Tx_Byte_Done,
    input  o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Data,
    input  i_Tx_Len,
    output o_Tx_Ready,
    output o_Tx_Active,
    output o_Tx_Serial,
    output o_Tx_Byte_Done,
    output o_Tx_Done
  );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: variable-length multi-byte UART transmitter, byte 0 first, LSB first.
// Define UART_TX_PARITY_EN to append a parity bit (sense PARITY_ODD) to every byte.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 217,
  parameter int NUM_BYTES    = 24,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_GAP     = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic           i_Clock,
  input  logic           i_Rst_n,
  uart_tx_frame_if.slave tx
);
  localparam int CW = $clog2(2 * CLKS_PER_BIT);
  localparam int LW = $clog2(NUM_BYTES + 1);
  localparam int GW = $clog2(IDLE_GAP + 2);
  localparam int DW = NUM_BYTES * 8;

  localparam logic [CW-1:0] BIT_END    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END   = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_PULSE = CW'(STOP_BITS * CLKS_PER_BIT - 2);
  localparam logic [GW-1:0] GAP_END    = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
  localparam logic [LW-1:0] LEN_MAX    = LW'(NUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    bit_idx;
  logic [LW-1:0] byte_idx;
  logic [LW-1:0] len_q;
  logic [DW-1:0] frame_q;
  logic          serial;
  logic          ready;
  logic          active;
  logic          byte_done;
  logic          done;

  logic [7:0] cur_byte;
  logic       last_byte;

  // The frame register shifts down one byte per sent byte,
  // so the byte on the wire is always the low byte.
  assign cur_byte  = frame_q[7:0];
  assign last_byte = (byte_idx + LW'(1)) == len_q;

`ifdef UART_TX_PARITY_EN
  logic par_bit;
  assign par_bit = (^cur_byte) ^ 1'(PARITY_ODD);
`endif

  assign tx.o_Tx_Serial    = serial;
  assign tx.o_Tx_Ready     = ready;
  assign tx.o_Tx_Active    = active;
  assign tx.o_Tx_Byte_Done = byte_done;
  assign tx.o_Tx_Done      = done;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gap_cnt   <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      len_q     <= '0;
      frame_q   <= '0;
      serial    <= 1'b1;
      ready     <= 1'b1;
      active    <= 1'b0;
      byte_done <= 1'b0;
      done      <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tx.i_Tx_DV && (tx.i_Tx_Len != '0)) begin
            frame_q  <= tx.i_Tx_Data;
            len_q    <= (tx.i_Tx_Len > LEN_MAX) ? LEN_MAX
                                                : tx.i_Tx_Len;
            byte_idx <= '0;
            cnt      <= '0;
            ready    <= 1'b0;
            active   <= 1'b1;
            serial   <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            serial  <= cur_byte[0];
            state   <= S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              serial <= par_bit;
              state  <= S_PARITY;
`else
              serial <= 1'b1;
              state  <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              serial  <= cur_byte[bit_idx+3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (cnt == BIT_END) begin
            cnt    <= '0;
            serial <= 1'b1;
            state  <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          // Pulses are registered, so arm them one cycle early
          // to land on the final stop cycle.
          if (cnt == STOP_PULSE) begin
            byte_done <= 1'b1;
            done      <= last_byte;
          end
          if (cnt == STOP_END) begin
            cnt <= '0;
            if (last_byte) begin
              active <= 1'b0;
              ready  <= 1'b1;
              state  <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + LW'(1);
              frame_q  <= frame_q >> 8;
              if (IDLE_GAP > 0) begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end else begin
                serial <= 1'b0;
                state  <= S_START;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_END) begin
            cnt    <= '0;
            serial <= 1'b0;
            state  <= S_START;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          serial <= 1'b1;
          ready  <= 1'b1;
          active <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule
